axis_128to32_packer: RTL and testbench

- Downstream stage of the 8-channel ADC capture wrapper.
- Accepts the wrapper's 128-bit AXI-Stream beats (four 32-bit channel words per beat), buffers them in a small FIFO, and re-emits them as a 32-bit AXI-Stream, one channel word per transfer.
- Propagates frame boundaries (tlast) and counts completed frames for the DMA/PS side.

---
 rtl/axis_128to32_packer.sv | 88 ++++++++
 tb/tb_axis_128to32_packer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_128to32_packer.sv
// Buffers 128-bit ADC capture beats in a small FIFO and re-emits them as
// 32-bit channel words, lowest word first, carrying tlast and counting frames.
module axis_128to32_packer #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             sck,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [LVL_W-1:0] fill_level,
  output logic [15:0]      frame_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [128:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [1:0]       word_idx;
  logic [15:0]      frame_q;
  logic [128:0]     head;
  logic             full;
  logic             empty;
  logic             push;
  logic             out_fire;
  logic             pop;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  // Input side never looks at m_axis_tready; a slot frees one cycle after the pop.
  assign s_axis_tready = start & ~full & ~rst;
  assign m_axis_tvalid = start & ~empty;
  assign m_axis_tdata  = empty ? 32'd0 : head[{word_idx, 5'd0} +: 32];
  assign m_axis_tlast  = head[128] & (word_idx == 2'd3) & m_axis_tvalid;

  assign push     = s_axis_tvalid & s_axis_tready;
  assign out_fire = m_axis_tvalid & m_axis_tready;
  assign pop      = out_fire & (word_idx == 2'd3);

  assign fill_level = level;
  assign frame_cnt  = frame_q;

  always_ff @(posedge sck) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      word_idx <= 2'd0;
      frame_q  <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (out_fire) begin
        word_idx <= word_idx + 2'd1;
      end
      if (out_fire && m_axis_tlast) begin
        frame_q <= frame_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_128to32_packer.sv
// Bench for axis_128to32_packer: queue-of-beats reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_axis_128to32_packer;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             sck;
  logic             rst;
  logic             start;
  logic [127:0]     s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [31:0]      m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  logic [LVL_W-1:0] fill_level;
  logic [15:0]      frame_cnt;

  axis_128to32_packer #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .sck           (sck),
    .rst           (rst),
    .start         (start),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tlast  (m_last),
    .m_axis_tready (m_ready),
    .fill_level    (fill_level),
    .frame_cnt     (frame_cnt)
  );

  initial begin
    sck = 1'b0;
    forever #5 sck = ~sck;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: whole beats waiting, index of next word in the head beat.
  logic [128:0] q[$];
  int           widx = 0;
  logic [15:0]  mframes = 16'd0;
  bit           last_push = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    logic [128:0] head;
    logic [31:0]  exp_d;
    bit           exp_v;
    bit           exp_l;
    exp_v = start && (q.size() > 0);
    exp_d = 32'd0;
    exp_l = 1'b0;
    if (q.size() > 0) begin
      head  = q[0];
      exp_d = head[widx*32 +: 32];
      exp_l = exp_v && head[128] && (widx == 3);
    end
    chk("m_tvalid", {127'd0, m_valid}, {127'd0, exp_v});
    chk("m_tdata", {96'd0, m_data}, {96'd0, exp_d});
    chk("m_tlast", {127'd0, m_last}, {127'd0, exp_l});
    chk("s_tready", {127'd0, s_ready}, {127'd0, (!rst && start && q.size() < DEPTH)});
    chk("fill_level", 128'(fill_level), 128'(q.size()));
    chk("frame_cnt", {112'd0, frame_cnt}, {112'd0, mframes});
  endtask

  task automatic model_step();
    bit hs;
    bit pu;
    logic [128:0] head;
    if (rst) begin
      q.delete();
      widx = 0;
      mframes = 16'd0;
      last_push = 1'b0;
      return;
    end
    hs = start && (q.size() > 0) && m_ready;
    pu = start && (q.size() < DEPTH) && s_valid;
    if (hs) begin
      head = q[0];
      if (head[128] && widx == 3) mframes = mframes + 16'd1;
      if (widx == 3) begin
        void'(q.pop_front());
        widx = 0;
      end else begin
        widx++;
      end
    end
    if (pu) q.push_back({s_last, s_data});
    last_push = pu;
  endtask

  // Compare in the middle of the cycle, advance the model on the edge,
  // then return 1 time unit after the edge for driving and literal checks.
  task automatic tick();
    @(negedge sck);
    compare();
    @(posedge sck);
    model_step();
    #1;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    s_valid = 1'b0;
    for (int b = 0; b < 100 && q.size() > 0; b++) tick();
    chk("drain_empty", 128'(fill_level), 128'd0);
  endtask

  logic [127:0] beat;
  logic [31:0]  w [4];
  int           k;
  bit           prev_rdy;

  initial begin
    rst = 1'b1; start = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    tick();
    chk("rst_fill", 128'(fill_level), 128'd0);
    chk("rst_mvalid", {127'd0, m_valid}, 128'd0);
    chk("rst_frame", {112'd0, frame_cnt}, 128'd0);
    chk("rst_mdata", {96'd0, m_data}, 128'd0);
    chk("rst_sready", {127'd0, s_ready}, 128'd0);
    start = 1'b1;
    #1;
    chk("start_sready", {127'd0, s_ready}, 128'd1);

    // Single beat, continuous ready
    m_ready = 1'b1;
    s_data = 128'h22222200_11111100_FFFFFF00_EEEEEE00;
    s_last = 1'b1;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    w[0] = 32'hEEEEEE00; w[1] = 32'hFFFFFF00; w[2] = 32'h11111100; w[3] = 32'h22222200;
    for (int i = 0; i < 4; i++) begin
      chk("t1_word", {96'd0, m_data}, {96'd0, w[i]});
      chk("t1_last", {127'd0, m_last}, {127'd0, (i == 3)});
      tick();
    end
    chk("t1_frame", {112'd0, frame_cnt}, 128'd1);
    chk("t1_fill", 128'(fill_level), 128'd0);

    // Fill to full with output stalled, one beat held upstream
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      s_last = 1'b1;
      s_valid = 1'b1;
      tick();
    end
    chk("t2_full", 128'(fill_level), 128'd4);
    chk("t2_sready_low", {127'd0, s_ready}, 128'd0);
    s_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    tick();
    chk("t2_held", 128'(fill_level), 128'd4);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t2_sready_before_pop", {127'd0, s_ready}, 128'd0);
    tick();
    chk("t2_sready_after_pop", {127'd0, s_ready}, 128'd1);
    tick();
    s_valid = 1'b0;
    drain();

    // Output ready toggling within a beat
    beat = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    w[0] = 32'hA0A0A0A0; w[1] = 32'hA1A1A1A1; w[2] = 32'hA2A2A2A2; w[3] = 32'hA3A3A3A3;
    m_ready = 1'b0;
    s_data = beat; s_last = 1'b0; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    k = 0;
    prev_rdy = 1'b0;
    for (int c = 0; c < 7; c++) begin
      m_ready = (c % 2 == 0);
      prev_rdy = m_ready;
      tick();
      if (prev_rdy) k++;
      if (k < 4) chk("t3_word", {96'd0, m_data}, {96'd0, w[k]});
    end
    drain();

    // start dropped after two words
    beat = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    m_ready = 1'b1;
    s_data = beat; s_last = 1'b1; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t4_mvalid_paused", {127'd0, m_valid}, 128'd0);
      chk("t4_sready_paused", {127'd0, s_ready}, 128'd0);
    end
    start = 1'b1;
    #1;
    chk("t4_resume_w2", {96'd0, m_data}, 128'hB2B2B2B2);
    tick();
    chk("t4_resume_w3", {96'd0, m_data}, 128'hB3B3B3B3);
    drain();

    // Reset with three beats queued, mid-beat
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      s_last = 1'b1;
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_fill", 128'(fill_level), 128'd0);
    chk("t5_mvalid", {127'd0, m_valid}, 128'd0);
    chk("t5_frame", {112'd0, frame_cnt}, 128'd0);
    s_data = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0; s_last = 1'b0; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("t5_first_word", {96'd0, m_data}, 128'hC0C0C0C0);
    drain();

    // frame_cnt wrap
    force dut.frame_q = 16'hFFFF;
    mframes = 16'hFFFF;
    #1;
    release dut.frame_q;
    #1;
    chk("t6_preload", {112'd0, frame_cnt}, 128'hFFFF);
    s_data = {$urandom(), $urandom(), $urandom(), $urandom()}; s_last = 1'b1; s_valid = 1'b1;
    tick();
    drain();
    chk("t6_wrap", {112'd0, frame_cnt}, 128'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!s_valid || last_push) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_last  = $urandom_range(0, 1);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      start   = ($urandom_range(0, 15) != 0);
      rst     = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    start = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
